logicnets_lut_layer: RTL and testbench

LOGICNETS_LUT_LAYER -- requirements
Module: logicnets_lut_layer

---
 rtl/logicnets_pkg.sv | 14 +
 rtl/logicnets_lut_ram.sv | 25 ++
 rtl/logicnets_lut_layer.sv | 110 +++++++++++
 tb/tb_logicnets_lut_layer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/logicnets_pkg.sv
// Shared types and helpers for the LogicNets LUT layer.
// Holds the sweep/run state encoding and a clog2 that never returns 0.
package logicnets_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/logicnets_lut_ram.sv
// One neuron truth table: 2^FAN_IN x OUT_BITS distributed RAM.
// Write lands on the clock edge; read is combinational; no backpressure.
module logicnets_lut_ram #(
    parameter int FAN_IN   = 6,
    parameter int OUT_BITS = 1
) (
    input  logic                clk,
    input  logic                we,
    input  logic [FAN_IN-1:0]   waddr,
    input  logic [OUT_BITS-1:0] wdata,
    input  logic [FAN_IN-1:0]   raddr,
    output logic [OUT_BITS-1:0] rdata
);

    logic [OUT_BITS-1:0] mem [2**FAN_IN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/logicnets_lut_layer.sv
// Layer of N_NEURONS LUT neurons with runtime-loadable tables and a clear sweep.
// Latency 1 cycle; in_ready drops on config activity, during CLEAR, or when the output is stalled.
module logicnets_lut_layer
    import logicnets_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int FAN_IN    = 6,
    parameter int OUT_BITS  = 1,
    localparam int NB       = clog2_min1(N_NEURONS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_NEURONS*FAN_IN-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_NEURONS*OUT_BITS-1:0] out_data,
    input  logic                          cfg_we,
    input  logic [NB-1:0]                 cfg_neuron,
    input  logic [FAN_IN-1:0]             cfg_addr,
    input  logic [OUT_BITS-1:0]           cfg_data,
    input  logic                          cfg_clear,
    output logic                          cfg_busy
);

    state_t                        state_q, state_d;
    logic [FAN_IN-1:0]             sweep_cnt, sweep_d;
    logic                          clearing;
    logic                          cfg_wr_ok;
    logic                          accept;
    logic [FAN_IN-1:0]             wr_addr;
    logic [OUT_BITS-1:0]           wr_data;
    logic [N_NEURONS*OUT_BITS-1:0] lut_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            sweep_cnt <= '0;
        end else begin
            state_q   <= state_d;
            sweep_cnt <= sweep_d;
        end
    end

    // cfg_clear is only looked at in RUN, so a clear request mid-sweep never restarts it.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_cnt;
        case (state_q)
            ST_CLEAR: begin
                sweep_d = sweep_cnt + 1'b1;
                if (sweep_cnt == {FAN_IN{1'b1}}) begin
                    state_d = ST_RUN;
                    sweep_d = '0;
                end
            end
            ST_RUN: begin
                if (cfg_clear) begin
                    state_d = ST_CLEAR;
                    sweep_d = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                sweep_d = '0;
            end
        endcase
    end

    assign clearing  = (state_q == ST_CLEAR);
    assign cfg_busy  = clearing;
    assign cfg_wr_ok = (state_q == ST_RUN) && cfg_we && !rst;
    assign in_ready  = (state_q == ST_RUN) && !cfg_we && !cfg_clear && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    // The sweep owns the write port while clearing; config writes get it otherwise.
    assign wr_addr = clearing ? sweep_cnt : cfg_addr;
    assign wr_data = clearing ? '0 : cfg_data;

    for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron
        logic we_i;
        assign we_i = clearing || (cfg_wr_ok && (cfg_neuron == NB'(i)));

        logicnets_lut_ram #(
            .FAN_IN   (FAN_IN),
            .OUT_BITS (OUT_BITS)
        ) u_ram (
            .clk   (clk),
            .we    (we_i),
            .waddr (wr_addr),
            .wdata (wr_data),
            .raddr (in_data[i*FAN_IN +: FAN_IN]),
            .rdata (lut_dat[i*OUT_BITS +: OUT_BITS])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= lut_dat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logicnets_lut_layer.sv
// Randomized bench for logicnets_lut_layer against a table/queue reference model.
module tb_logicnets_lut_layer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        cfg_we;
    logic [1:0]  cfg_neuron;
    logic [5:0]  cfg_addr;
    logic [0:0]  cfg_data;
    logic        cfg_clear;
    logic        cfg_busy;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: truth tables, pending output queue, sweep countdown
    logic       model [4][64];
    logic [3:0] q[$];
    bit         run_m;
    int         clr_left;

    logicnets_lut_layer #(
        .N_NEURONS (4),
        .FAN_IN    (6),
        .OUT_BITS  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cfg_we     (cfg_we),
        .cfg_neuron (cfg_neuron),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_clear  (cfg_clear),
        .cfg_busy   (cfg_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] lut(input logic [23:0] d);
        logic [3:0] r;
        for (int n = 0; n < 4; n++) begin
            r[n] = model[n][d[n*6 +: 6]];
        end
        return r;
    endfunction

    task automatic model_zero();
        for (int n = 0; n < 4; n++)
            for (int a = 0; a < 64; a++)
                model[n][a] = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0; cfg_clear = 1'b0;
        in_data = '0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
        end
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(cfg_busy), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        q.delete();
        run_m = 1'b0;
        clr_left = 64;
    endtask

    // One clock cycle: drive, check combinational and held outputs, advance model and DUT.
    task automatic cycle(input logic iv, input logic [23:0] id, input logic ordy,
                         input logic we, input logic [1:0] nr, input logic [5:0] ad,
                         input logic dt, input logic clr, output bit acc);
        bit exp_rdy;
        in_valid = iv; in_data = id; out_ready = ordy; cfg_we = we;
        cfg_neuron = nr; cfg_addr = ad; cfg_data = dt; cfg_clear = clr;
        #1;
        exp_rdy = run_m && !we && !clr && (q.size() == 0 || ordy);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("cfg_busy", 32'(cfg_busy), 32'(!run_m));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
        if (q.size() != 0 && ordy) void'(q.pop_front());
        acc = iv && exp_rdy;
        if (acc) q.push_back(lut(id));
        if (we && run_m) model[nr][ad] = dt;
        if (run_m && clr) begin
            run_m = 1'b0;
            clr_left = 64;
            model_zero();
        end else if (!run_m) begin
            clr_left--;
            if (clr_left == 0) run_m = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        bit a;
        for (int c = 0; c < n; c++) cycle(1'b0, '0, ordy, 1'b0, '0, '0, 1'b0, 1'b0, a);
    endtask

    task automatic rand_cycles(input int n, input bit writes, input bit clears);
        bit a;
        for (int c = 0; c < n; c++) begin
            cycle(1'($urandom_range(0, 1)), 24'($urandom), $urandom_range(0, 3) != 0,
                  writes && ($urandom_range(0, 4) == 0), 2'($urandom), 6'($urandom),
                  1'($urandom), clears && ($urandom_range(0, 199) == 0), a);
        end
    endtask

    initial begin
        bit         a;
        int         idx;
        int         k;
        logic [23:0] vec [8];
        logic [23:0] d;

        model_zero();
        @(posedge clk); #1;
        do_reset(3);

        // post-reset sweep must be exactly 64 busy cycles, then an all-ones lookup reads zeros
        idle(66, 1'b1);
        cycle(1'b1, 24'hFFFFFF, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, a);
        chk("ffffff_out", 32'(out_data), 32'h0);
        idle(1, 1'b1);

        // single entry write then lookup hitting it
        cycle(1'b0, '0, 1'b1, 1'b1, 2'd2, 6'b011000, 1'b1, 1'b0, a);
        cycle(1'b1, 24'(6'b011000) << 12, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, a);
        chk("n2_hit", 32'(out_data), 32'b0100);
        idle(1, 1'b1);

        rand_cycles(200, 1'b1, 1'b0);
        idle(2, 1'b1);

        // stream 8 vectors, downstream stalls on cycles 3..5, upstream holds until accepted
        for (int v = 0; v < 8; v++) vec[v] = 24'($urandom);
        idx = 0;
        k = 1;
        while (idx < 8 && k < 40) begin
            cycle(1'b1, vec[idx], !(k >= 3 && k <= 5), 1'b0, '0, '0, 1'b0, 1'b0, a);
            if (a) idx++;
            k++;
        end
        chk("stream_done", 32'(idx), 32'd8);
        idle(3, 1'b1);

        // write and input collide: write wins, input retried next cycle sees new entry
        d = 24'($urandom);
        cycle(1'b1, d, 1'b1, 1'b1, 2'd1, d[11:6], ~model[1][d[11:6]], 1'b0, a);
        chk("collide_no_acc", 32'(a), 32'd0);
        cycle(1'b1, d, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, a);
        chk("retry_out", 32'(out_data), 32'(lut(d)));
        idle(1, 1'b1);

        // clear with a held output: output survives the sweep until drained, tables read zero after
        cycle(1'b1, 24'($urandom), 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, a);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, a);
        idle(10, 1'b0);
        idle(60, 1'b1);
        rand_cycles(40, 1'b0, 1'b0);
        rand_cycles(150, 1'b1, 1'b1);
        idle(70, 1'b1);

        // reset 30 cycles into a sweep while an output is held
        cycle(1'b1, 24'($urandom), 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, a);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, a);
        idle(29, 1'b0);
        chk("pre_rst_held", 32'(out_valid), 32'd1);
        do_reset(1);
        idle(66, 1'b1);
        rand_cycles(120, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
